// File: rtl/wb_commit_arbiter.sv
// Round-robin write-back arbiter feeding an in-order commit FIFO drained through one register-file port.
// Optional youngest-match bypass lookup over buffered writes is enabled by defining WB_BYPASS_EN.
module wb_commit_arbiter #(
  parameter int XLEN    = 64,
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH-1:0]        in_we,
  input  logic [NUM_CH*5-1:0]      in_rd,
  input  logic [NUM_CH*XLEN-1:0]   in_data,
  output logic [4:0]               regWriteAddr,
  output logic [XLEN-1:0]          regWriteData,
  output logic                     regWriteEn,
  input  logic                     regWriteDone,
  output logic [4:0]               regClearAddr,
  output logic                     retire_valid,
  output logic [CH_W-1:0]          retire_ch,
  output logic [CNT_W-1:0]         fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  input  logic [4:0]               byp_addr,
  output logic                     byp_hit,
  output logic [XLEN-1:0]          byp_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [CH_W-1:0]  rr_ptr, sel, arb_cand;
  int               arb_pos;
  logic             found, push, pop, head_write;

  logic             we_q   [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [CH_W-1:0]  ch_q   [DEPTH];

  logic [4:0]       rd_ch   [NUM_CH];
  logic [XLEN-1:0]  data_ch [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign rd_ch[g]   = in_rd[5*g +: 5];
    assign data_ch[g] = in_data[XLEN*g +: XLEN];
  end

  assign fifo_count = count;
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);

  // First requester at or after the RR pointer, wrapping modulo NUM_CH.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    arb_pos  = 0;
    arb_cand = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_pos = int'(rr_ptr) + k;
      if (arb_pos >= NUM_CH) arb_pos = arb_pos - NUM_CH;
      arb_cand = CH_W'(arb_pos);
      if (!found && in_valid[arb_cand]) begin
        found = 1'b1;
        sel   = arb_cand;
      end
    end
  end

  // Full blocks the grant even when the head pops this cycle.
  assign push = found && !fifo_full;

  always_comb begin
    in_ready = '0;
    if (push) in_ready[sel] = 1'b1;
  end

  assign head_write   = !fifo_empty && we_q[head] && (rd_q[head] != 5'd0);
  assign regWriteEn   = head_write;
  assign regWriteAddr = head_write ? rd_q[head] : 5'd0;
  assign regWriteData = head_write ? data_q[head] : '0;
  assign pop          = !fifo_empty && (!head_write || regWriteDone);

  always_ff @(posedge clk) begin
    if (push) begin
      we_q[tail]   <= in_we[sel];
      rd_q[tail]   <= rd_ch[sel];
      data_q[tail] <= data_ch[sel];
      ch_q[tail]   <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      rr_ptr       <= '0;
      retire_valid <= 1'b0;
      retire_ch    <= '0;
      regClearAddr <= 5'd0;
    end else begin
      if (push) begin
        tail   <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;
        rr_ptr <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
      end
      if (pop) head <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      retire_valid <= pop;
      if (pop) begin
        retire_ch    <= ch_q[head];
        regClearAddr <= head_write ? rd_q[head] : 5'd0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  int               byp_pos;
  logic [PTR_W-1:0] byp_idx;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_pos  = 0;
    byp_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      byp_pos = int'(head) + k;
      if (byp_pos >= DEPTH) byp_pos = byp_pos - DEPTH;
      byp_idx = PTR_W'(byp_pos);
      if ((k < int'(count)) && we_q[byp_idx] && (rd_q[byp_idx] == byp_addr) && (byp_addr != 5'd0)) begin
        byp_hit  = 1'b1;
        byp_data = data_q[byp_idx];
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^byp_addr;
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Self-checking bench for wb_commit_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the commit stage.
module tb_wb_commit_arbiter;
  localparam int XLEN = 64, NUM_CH = 4, DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_CH-1:0]      in_valid, in_ready, in_we;
  logic [NUM_CH*5-1:0]    in_rd;
  logic [NUM_CH*XLEN-1:0] in_data;
  logic [4:0]             regWriteAddr, regClearAddr, byp_addr;
  logic [XLEN-1:0]        regWriteData, byp_data;
  logic                   regWriteEn, regWriteDone, retire_valid, fifo_full, fifo_empty, byp_hit;
  logic [1:0]             retire_ch;
  logic [2:0]             fifo_count;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    bit             we;
    bit [4:0]       rd;
    bit [XLEN-1:0]  data;
    int             ch;
  } ent_t;

  wb_commit_arbiter #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_rd(in_rd), .in_data(in_data), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
    .regWriteEn(regWriteEn), .regWriteDone(regWriteDone), .regClearAddr(regClearAddr),
    .retire_valid(retire_valid), .retire_ch(retire_ch), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .byp_addr(byp_addr), .byp_hit(byp_hit),
    .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0; in_we = '0; in_rd = '0; in_data = '0;
    regWriteDone = 1'b0; byp_addr = 5'd0;
  endtask

  task automatic set_ch(input int c, input bit we, input logic [4:0] rd, input logic [XLEN-1:0] d);
    in_we[c] = we;
    in_rd[5*c +: 5] = rd;
    in_data[XLEN*c +: XLEN] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (regWriteEn !== 1'b0) $display("FAIL reset_en got %b exp 0", regWriteEn); else n_pass++;
    n_chk++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", fifo_empty); else n_pass++;
    n_chk++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", fifo_count); else n_pass++;
    n_chk++; if (in_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", in_ready); else n_pass++;
    n_chk++; if (retire_valid !== 1'b0) $display("FAIL reset_rv got %b exp 0", retire_valid); else n_pass++;
    n_chk++; if (byp_hit !== 1'b0) $display("FAIL reset_byp got %b exp 0", byp_hit); else n_pass++;
    tick();
  endtask

  task automatic test_single();
    idle();
    do_reset();
    set_ch(0, 1'b1, 5'd5, 64'hDEAD);
    in_valid = 4'b0001;
    @(negedge clk);
    n_chk++; if (in_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", in_ready); else n_pass++;
    tick();
    in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      regWriteDone = (c == 2);
      @(negedge clk);
      n_chk++; if (regWriteEn !== 1'b1) $display("FAIL single_en c%0d got %b exp 1", c, regWriteEn); else n_pass++;
      n_chk++; if (regWriteAddr !== 5'd5) $display("FAIL single_addr c%0d got %0d exp 5", c, regWriteAddr); else n_pass++;
      n_chk++; if (regWriteData !== 64'hDEAD) $display("FAIL single_data c%0d got %h exp dead", c, regWriteData); else n_pass++;
      n_chk++; if (retire_valid !== 1'b0) $display("FAIL single_early_rv c%0d got %b exp 0", c, retire_valid); else n_pass++;
      tick();
    end
    regWriteDone = 1'b0;
    @(negedge clk);
    n_chk++; if (retire_valid !== 1'b1) $display("FAIL single_rv got %b exp 1", retire_valid); else n_pass++;
    n_chk++; if (regClearAddr !== 5'd5) $display("FAIL single_clr got %0d exp 5", regClearAddr); else n_pass++;
    n_chk++; if (retire_ch !== 2'd0) $display("FAIL single_rch got %0d exp 0", retire_ch); else n_pass++;
    n_chk++; if (fifo_empty !== 1'b1) $display("FAIL single_empty got %b exp 1", fifo_empty); else n_pass++;
    n_chk++; if (regWriteEn !== 1'b0) $display("FAIL single_en_after got %b exp 0", regWriteEn); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++; if (retire_valid !== 1'b0) $display("FAIL single_rv_pulse got %b exp 0", retire_valid); else n_pass++;
    tick();
  endtask

  task automatic test_rr_all();
    int got_ch[$];
    int got_clr[$];
    logic [3:0] exp_rdy;
    idle();
    do_reset();
    regWriteDone = 1'b1;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 5'(i + 1), 64'(256 + i));
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 5) ? 4'hF : 4'h0;
      @(negedge clk);
      exp_rdy = (c < 5) ? 4'(1 << (c % 4)) : 4'h0;
      n_chk++; if (in_ready !== exp_rdy) $display("FAIL rr_grant c%0d got %b exp %b", c, in_ready, exp_rdy); else n_pass++;
      if (retire_valid === 1'b1) begin
        got_ch.push_back(int'(retire_ch));
        got_clr.push_back(int'(regClearAddr));
      end
      tick();
    end
    n_chk++; if (got_ch.size() != 5) $display("FAIL rr_retire_count got %0d exp 5", got_ch.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i < got_ch.size()) begin
        n_chk++; if (got_ch[i] != i % 4) $display("FAIL rr_retire_ch[%0d] got %0d exp %0d", i, got_ch[i], i % 4); else n_pass++;
        n_chk++; if (got_clr[i] != i % 4 + 1) $display("FAIL rr_retire_clr[%0d] got %0d exp %0d", i, got_clr[i], i % 4 + 1); else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_full();
    int acc;
    acc = 0;
    idle();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_ch(0, 1'b1, 5'(acc + 1), 64'(acc));
      in_valid = (acc < 5) ? 4'b0001 : 4'b0000;
      regWriteDone = (c == 5);
      @(negedge clk);
      if (c < 4) begin
        n_chk++; if (in_ready !== 4'b0001) $display("FAIL full_fill_ready c%0d got %b exp 0001", c, in_ready); else n_pass++;
        n_chk++; if (fifo_count !== 3'(c)) $display("FAIL full_fill_count c%0d got %0d exp %0d", c, fifo_count, c); else n_pass++;
      end else if (c == 4) begin
        n_chk++; if (fifo_full !== 1'b1) $display("FAIL full_flag got %b exp 1", fifo_full); else n_pass++;
        n_chk++; if (in_ready !== 4'b0000) $display("FAIL full_ready got %b exp 0000", in_ready); else n_pass++;
        n_chk++; if (fifo_count !== 3'd4) $display("FAIL full_count got %0d exp 4", fifo_count); else n_pass++;
      end else if (c == 5) begin
        n_chk++; if (in_ready !== 4'b0000) $display("FAIL full_pop_ready got %b exp 0000", in_ready); else n_pass++;
        n_chk++; if (regWriteAddr !== 5'd1) $display("FAIL full_pop_addr got %0d exp 1", regWriteAddr); else n_pass++;
      end else if (c == 6) begin
        n_chk++; if (in_ready !== 4'b0001) $display("FAIL full_refill_ready got %b exp 0001", in_ready); else n_pass++;
        n_chk++; if (fifo_count !== 3'd3) $display("FAIL full_refill_count got %0d exp 3", fifo_count); else n_pass++;
        n_chk++; if (regClearAddr !== 5'd1 || retire_valid !== 1'b1) $display("FAIL full_retire got rv=%b clr=%0d exp rv=1 clr=1", retire_valid, regClearAddr); else n_pass++;
      end else begin
        n_chk++; if (fifo_count !== 3'd4 || fifo_full !== 1'b1) $display("FAIL full_final got count=%0d full=%b exp 4 1", fifo_count, fifo_full); else n_pass++;
      end
      if (in_valid[0] && in_ready[0]) acc++;
      tick();
    end
    in_valid = '0;
    regWriteDone = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++; if (regWriteAddr !== 5'(i + 2)) $display("FAIL full_drain_addr[%0d] got %0d exp %0d", i, regWriteAddr, i + 2); else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++; if (fifo_empty !== 1'b1) $display("FAIL full_drained got %b exp 1", fifo_empty); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_null();
    idle();
    do_reset();
    set_ch(1, 1'b0, 5'd9, 64'h99);
    in_valid = 4'b0010;
    @(negedge clk);
    n_chk++; if (in_ready !== 4'b0010) $display("FAIL null_ready0 got %b exp 0010", in_ready); else n_pass++;
    tick();
    set_ch(2, 1'b1, 5'd0, 64'h77);
    in_valid = 4'b0100;
    @(negedge clk);
    n_chk++; if (in_ready !== 4'b0100) $display("FAIL null_ready1 got %b exp 0100", in_ready); else n_pass++;
    n_chk++; if (regWriteEn !== 1'b0) $display("FAIL null_en0 got %b exp 0", regWriteEn); else n_pass++;
    tick();
    in_valid = '0;
    @(negedge clk);
    n_chk++; if (retire_valid !== 1'b1 || retire_ch !== 2'd1) $display("FAIL null_retire0 got rv=%b ch=%0d exp rv=1 ch=1", retire_valid, retire_ch); else n_pass++;
    n_chk++; if (regClearAddr !== 5'd0) $display("FAIL null_clr0 got %0d exp 0", regClearAddr); else n_pass++;
    n_chk++; if (regWriteEn !== 1'b0) $display("FAIL null_en1 got %b exp 0", regWriteEn); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++; if (retire_valid !== 1'b1 || retire_ch !== 2'd2) $display("FAIL null_retire1 got rv=%b ch=%0d exp rv=1 ch=2", retire_valid, retire_ch); else n_pass++;
    n_chk++; if (regClearAddr !== 5'd0) $display("FAIL null_clr1 got %0d exp 0", regClearAddr); else n_pass++;
    n_chk++; if (fifo_empty !== 1'b1) $display("FAIL null_empty got %b exp 1", fifo_empty); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    do_reset();
    in_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      set_ch(0, 1'b1, 5'(c + 1), 64'(c));
      tick();
    end
    in_valid = '0;
    @(negedge clk);
    n_chk++; if (regWriteEn !== 1'b1 || fifo_count !== 3'd3) $display("FAIL rstmid_pre got en=%b count=%0d exp 1 3", regWriteEn, fifo_count); else n_pass++;
    tick();
    do_reset();
    @(negedge clk);
    n_chk++; if (regWriteEn !== 1'b0) $display("FAIL rstmid_en got %b exp 0", regWriteEn); else n_pass++;
    n_chk++; if (fifo_count !== 3'd0) $display("FAIL rstmid_count got %0d exp 0", fifo_count); else n_pass++;
    n_chk++; if (retire_valid !== 1'b0) $display("FAIL rstmid_rv got %b exp 0", retire_valid); else n_pass++;
    tick();
    regWriteDone = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (retire_valid !== 1'b0 || regWriteEn !== 1'b0) $display("FAIL rstmid_ghost c%0d got rv=%b en=%b exp 0 0", c, retire_valid, regWriteEn); else n_pass++;
      tick();
    end
    idle();
  endtask

  task automatic test_bypass();
    logic [4:0]      addrs [4];
    logic            exp_hit [4];
    logic [XLEN-1:0] exp_dat [4];
    addrs = '{5'd7, 5'd0, 5'd8, 5'd3};
    exp_hit = '{BYP, 1'b0, 1'b0, BYP};
    exp_dat = '{BYP ? 64'h22 : 64'h0, 64'h0, 64'h0, BYP ? 64'h33 : 64'h0};
    idle();
    do_reset();
    in_valid = 4'b0001;
    set_ch(0, 1'b1, 5'd7, 64'h11); tick();
    set_ch(0, 1'b1, 5'd7, 64'h22); tick();
    set_ch(0, 1'b1, 5'd3, 64'h33); tick();
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      byp_addr = addrs[i];
      @(negedge clk);
      n_chk++; if (byp_hit !== exp_hit[i]) $display("FAIL byp_hit a%0d got %b exp %b", addrs[i], byp_hit, exp_hit[i]); else n_pass++;
      n_chk++; if (byp_data !== exp_dat[i]) $display("FAIL byp_data a%0d got %h exp %h", addrs[i], byp_data, exp_dat[i]); else n_pass++;
      tick();
    end
    do_reset();
    set_ch(0, 1'b1, 5'd6, 64'h66);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    regWriteDone = 1'b1;
    byp_addr = 5'd6;
    @(negedge clk);
    n_chk++; if (byp_hit !== BYP || byp_data !== (BYP ? 64'h66 : 64'h0)) $display("FAIL byp_popping got hit=%b data=%h exp hit=%b", byp_hit, byp_data, BYP); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    int rr, g, c;
    bit wr, pop, e_rv, ehit;
    int e_rch;
    logic [4:0] e_rclr;
    logic [3:0] exp_rdy;
    logic [XLEN-1:0] edat;
    idle();
    do_reset();
    rr = 0; e_rv = 0; e_rch = 0; e_rclr = 5'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid = 4'($urandom);
      in_we = 4'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
        in_rd[5*i +: 5] = 5'($urandom_range(0, 7));
        in_data[XLEN*i +: XLEN] = {$urandom, $urandom};
      end
      regWriteDone = ($urandom_range(0, 2) != 0);
      byp_addr = 5'($urandom_range(0, 8));
      reset = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      g = -1;
      if (q.size() < DEPTH) begin
        for (int k = 0; k < NUM_CH; k++) begin
          c = (rr + k) % NUM_CH;
          if (in_valid[c]) begin g = c; break; end
        end
      end
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
      wr = (q.size() > 0) && q[0].we && (q[0].rd != 0);
      ehit = 1'b0; edat = '0;
      if (BYP && byp_addr != 0) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].we && q[i].rd == byp_addr) begin ehit = 1'b1; edat = q[i].data; break; end
        end
      end
      n_chk++; if (in_ready !== exp_rdy) $display("FAIL rnd_ready cyc%0d got %b exp %b", cyc, in_ready, exp_rdy); else n_pass++;
      n_chk++; if (regWriteEn !== wr) $display("FAIL rnd_en cyc%0d got %b exp %b", cyc, regWriteEn, wr); else n_pass++;
      n_chk++; if (regWriteAddr !== (wr ? q[0].rd : 5'd0)) $display("FAIL rnd_addr cyc%0d got %0d", cyc, regWriteAddr); else n_pass++;
      n_chk++; if (regWriteData !== (wr ? q[0].data : 64'h0)) $display("FAIL rnd_data cyc%0d got %h", cyc, regWriteData); else n_pass++;
      n_chk++; if (fifo_count !== 3'(q.size())) $display("FAIL rnd_count cyc%0d got %0d exp %0d", cyc, fifo_count, q.size()); else n_pass++;
      n_chk++; if (fifo_full !== (q.size() == DEPTH) || fifo_empty !== (q.size() == 0)) $display("FAIL rnd_flags cyc%0d got full=%b empty=%b size %0d", cyc, fifo_full, fifo_empty, q.size()); else n_pass++;
      n_chk++; if (retire_valid !== e_rv) $display("FAIL rnd_rv cyc%0d got %b exp %b", cyc, retire_valid, e_rv); else n_pass++;
      n_chk++; if (retire_ch !== 2'(e_rch) || regClearAddr !== e_rclr) $display("FAIL rnd_retire cyc%0d got ch=%0d clr=%0d exp ch=%0d clr=%0d", cyc, retire_ch, regClearAddr, e_rch, e_rclr); else n_pass++;
      n_chk++; if (byp_hit !== ehit || byp_data !== edat) $display("FAIL rnd_byp cyc%0d got hit=%b data=%h exp hit=%b data=%h", cyc, byp_hit, byp_data, ehit, edat); else n_pass++;
      if (reset) begin
        q.delete(); rr = 0; e_rv = 0; e_rch = 0; e_rclr = 5'd0;
      end else begin
        pop = (q.size() > 0) && (!wr || regWriteDone);
        e_rv = pop;
        if (pop) begin
          e_rch = q[0].ch;
          e_rclr = wr ? q[0].rd : 5'd0;
          void'(q.pop_front());
        end
        if (g >= 0) begin
          e.we = in_we[g]; e.rd = in_rd[5*g +: 5]; e.data = in_data[XLEN*g +: XLEN]; e.ch = g;
          q.push_back(e);
          rr = (g + 1) % NUM_CH;
        end
      end
      tick();
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_single();
    test_rr_all();
    test_full();
    test_null();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_commit_arbiter.md
Name: wb_commit_arbiter

Overview:
Parametrised multi-channel write-back stage. Accepts completed results from NUM_CH producer channels (ALU, load unit, ECALL unit, etc.) through valid/ready handshakes and round-robin arbitration. Buffers them in an in-order commit FIFO of DEPTH entries, then drains the FIFO through the single register-file write port with the regWriteEn/regWriteDone handshake. Reports each retirement, including the scoreboard clear address.

Parameters:
XLEN, 64, register data width
NUM_CH, 4, number of producer channels (>=1)
DEPTH, 4, commit FIFO entries (>=2; any integer, explicit wrap)
CH_W, $clog2(NUM_CH) (min 1), channel-id width (derived localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  NUM_CH  per-channel result valid
in_ready  out  NUM_CH  per-channel accept (one-hot or 0)
in_we  in  NUM_CH  per-channel register-write request
in_rd  in  NUM_CH*5  flattened destination registers, channel i at [5i+4:5i]
in_data  in  NUM_CH*XLEN  flattened result data
regWriteAddr  out  5  register-file write address
regWriteData  out  XLEN  register-file write data
regWriteEn  out  1  register-file write request
regWriteDone  in  1  register-file write acknowledge
regClearAddr  out  5  scoreboard clear address, valid with retire_valid
retire_valid  out  1  one-cycle retirement pulse
retire_ch  out  CH_W  source channel of the retired entry
fifo_count  out  $clog2(DEPTH+1)  occupancy
fifo_full  out  1  fifo_count==DEPTH
fifo_empty  out  1  fifo_count==0
byp_addr  in  5  bypass lookup register
byp_hit  out  1  bypass hit
byp_data  out  XLEN  bypass data

Behaviour:
- Reset (synchronous, active-high): head, tail, count and RR pointer are set to 0; retire_valid, retire_ch and regClearAddr are set to 0. All buffered entries are discarded. After the reset edge, regWriteEn=0, fifo_empty=1 and in_ready=0.
- Arbitration:
  - Search starts at the RR pointer and wraps modulo NUM_CH. The first channel with in_valid=1 gets in_ready=1, combinationally.
  - No grant is issued when fifo_full, even if a pop occurs in the same cycle.
  - A transfer happens when in_valid&in_ready. On a transfer, the RR pointer moves to (granted+1) mod NUM_CH. Without a transfer, the pointer holds.
  - At most one push per cycle.
- FIFO entry fields: {we, rd, data, ch}. Tail increments on push and head on pop, each wrapping DEPTH-1 -> 0. Count is updated as +1, -1, or unchanged on simultaneous push+pop.
- Head classification:
  - Write entry: we=1 and rd!=0.
  - Null entry: we=0 or rd=0.
- Drive (combinational from head state):
  - When non-empty and the head is a write entry: regWriteEn=1, regWriteAddr=head.rd, regWriteData=head.data.
  - Otherwise: regWriteEn=0, addr=0, data=0.
- Pop rules:
  - Write entry: pops on the edge where regWriteEn&regWriteDone. regWriteEn and the write data stay stable until then.
  - Null entry: pops on the next edge, with no register write.
  - regWriteDone while regWriteEn=0 is ignored.
- Retirement (registered, the cycle after a pop):
  - retire_valid=1 for one cycle and retire_ch=entry.ch.
  - regClearAddr=entry.rd for write entries, 0 for null entries.
  - If there is no pop, retire_valid=0 and the other two outputs hold their values.
- Latency: from accept into an empty FIFO to regWriteEn is 1 cycle. Throughput is 1 entry per cycle when regWriteDone is tied high.
- Ordering: retirement follows strict acceptance order.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - byp_hit=1 when some valid FIFO entry is a write entry with rd==byp_addr and byp_addr!=0.
  - byp_data is the data of the youngest such entry (closest to tail). Purely combinational.
  - Entries popping in the current cycle still count.
- Undefined: byp_hit=0 and byp_data=0 constantly; the ports remain present.

Test Plan:
- One entry, ch0 rd=5 data=0xDEAD, regWriteDone raised 2 cycles after regWriteEn rises -> regWriteEn=1 for 3 cycles with addr=5 and data=0xDEAD. Next cycle: retire_valid=1, regClearAddr=5, retire_ch=0, fifo_empty=1.
- NUM_CH=4, all channels valid at once (rd=1..4), regWriteDone tied 1 -> accepted ch0,1,2,3 on consecutive cycles; retire_ch sequence 0,1,2,3; with continuous valids, the RR pointer wraps to 0.
- DEPTH=4, regWriteDone=0, 5 results offered -> fifo_full after 4 accepts and in_ready=0. One regWriteDone pulse -> pop; the 5th result is accepted the following cycle and count returns to 4.
- Entries with we=0 (rd=9) and with we=1 rd=0 -> each retires one cycle after reaching head; regWriteEn never 1; regClearAddr=0.
- Reset asserted with 3 entries buffered and regWriteEn=1 -> next cycle regWriteEn=0, fifo_count=0, retire_valid=0; no retirement for the discarded entries.
- WB_BYPASS_EN with pending rd=7 0x11, then rd=7 0x22, regWriteDone=0 -> byp_addr=7 gives hit=1, data=0x22. byp_addr=0 or 8 gives hit=0. Without the macro, hit is always 0.
